// File: rtl/bla_serial_sub_if.sv
// Start/ready/done handshake and operand/result bus for the serial borrow-lookahead subtractor.
interface bla_serial_sub_if #(
  parameter int nBITS = 16
);
  logic             start;
  logic [nBITS-1:0] ain;
  logic [nBITS-1:0] bin;
  logic             bbin;
  logic             ready;
  logic [nBITS-1:0] diff;
  logic             bout;
  logic             overflow;
  logic             done;

  modport master (
    output start, ain, bin, bbin,
    input  ready, diff, bout, overflow, done
  );

  modport slave (
    input  start, ain, bin, bbin,
    output ready, diff, bout, overflow, done
  );
endinterface

// File: rtl/bla_serial_sub.sv
// Multi-cycle A - B - bbin, one 4-bit borrow-lookahead slice per clock, LSB nibble first.
// Optional SUB_SATURATE_EN: clamp diff to the signed range on two's-complement overflow.
module bla_serial_sub #(
  parameter int nBITS = 16
) (
  input  logic            clk,
  input  logic            reset,
  bla_serial_sub_if.slave bus
);
  localparam int SLICES = nBITS / 4;
  localparam int CNT_W  = (SLICES > 1) ? $clog2(SLICES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [nBITS-1:0] a_p0, b_p0, acc_p0;
  logic             brw_p0;
  logic             accept, last;
  logic [4:0]       slc;
  logic [nBITS-1:0] raw;
  logic             ov;

  // Returns {c4, d[3:0]}; borrows expanded flat so no ripple inside the slice.
  function automatic logic [4:0] slice_sub(input logic [3:0] a, input logic [3:0] b,
                                           input logic c0);
    logic [3:0] g, p;
    logic [4:0] c;
    g    = ~a & b;
    p    = ~(a ^ b);
    c[0] = c0;
    c[1] = g[0] | (p[0] & c0);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c0);
    return {c[4], a ^ b ^ c[3:0]};
  endfunction

`ifdef SUB_SATURATE_EN
  function automatic logic [nBITS-1:0] sat_diff(input logic [nBITS-1:0] r, input logic ovf,
                                                input logic a_msb);
    if (!ovf)
      return r;
    return a_msb ? {1'b1, {(nBITS-1){1'b0}}} : {1'b0, {(nBITS-1){1'b1}}};
  endfunction
`endif

  assign accept    = bus.start & bus.ready;
  assign last      = (cnt_q == CNT_W'(SLICES - 1));
  assign slc       = slice_sub(a_p0[4*cnt_q +: 4], b_p0[4*cnt_q +: 4], brw_p0);
  assign bus.ready = (state_q == IDLE) || (state_q == DONE);
  assign bus.done  = (state_q == DONE);

  // The top nibble is still combinational when the last slice is processed.
  always_comb begin
    raw              = acc_p0;
    raw[nBITS-1 -: 4] = slc[3:0];
  end

  assign ov = (a_p0[nBITS-1] != b_p0[nBITS-1]) && (raw[nBITS-1] != a_p0[nBITS-1]);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    state_d = bus.start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept)
        cnt_q <= '0;
      else if (state_q == RUN)
        cnt_q <= last ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Work registers: operands latched on accept, then one slice per cycle.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_p0   <= bus.ain;
      b_p0   <= bus.bin;
      brw_p0 <= bus.bbin;
    end else if (state_q == RUN) begin
      acc_p0[4*cnt_q +: 4] <= slc[3:0];
      brw_p0               <= slc[4];
    end
  end

  // Result registers: updated only on the completion edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.diff     <= '0;
      bus.bout     <= 1'b0;
      bus.overflow <= 1'b0;
    end else if (state_q == RUN && last) begin
`ifdef SUB_SATURATE_EN
      bus.diff     <= sat_diff(raw, ov, a_p0[nBITS-1]);
`else
      bus.diff     <= raw;
`endif
      bus.bout     <= slc[4];
      bus.overflow <= ov;
    end
  end
endmodule

// File: tb/tb_bla_serial_sub.sv
// Bench for bla_serial_sub: table vectors, handshake corner sequences and random ops via a scoreboard.
module tb_bla_serial_sub;
  localparam int NB = 16;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  bla_serial_sub_if #(.nBITS(NB)) bus ();
  bla_serial_sub #(.nBITS(NB)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        bb;
    logic [15:0] d;
    logic        bo;
    logic        ov;
  } vec_t;

  typedef struct {
    logic [15:0] d;
    logic        bo;
    logic        ov;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   n_chk    = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   done_cnt = 0;
  logic prev_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic bb);
    exp_t e;
    logic [16:0] r;
    r    = {1'b0, a} - {1'b0, b} - {16'd0, bb};
    e.d  = r[15:0];
    e.bo = r[16];
    e.ov = (a[15] != b[15]) && (r[15] != a[15]);
`ifdef SUB_SATURATE_EN
    if (e.ov) e.d = a[15] ? 16'h8000 : 16'h7FFF;
`endif
    e.acc = 0;
    return e;
  endfunction

  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      exp_t e;
      done_cnt++;
      chk("done_single_cycle", {31'd0, prev_done}, 32'd0);
      chk("ready_in_done", {31'd0, bus.ready}, 32'd1);
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_done: got done pulse, expected none pending");
      end else begin
        e = sb.pop_front();
        chk("diff", {16'd0, bus.diff}, {16'd0, e.d});
        chk("bout", {31'd0, bus.bout}, {31'd0, e.bo});
        chk("overflow", {31'd0, bus.overflow}, {31'd0, e.ov});
        chk("latency", cyc - e.acc, 32'd4);
      end
    end
    prev_done = bus.done;
  end

  // Call at a negedge; drives start for the next edge once ready and returns one negedge later.
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic bb,
                       input logic [15:0] d, input logic bo, input logic ov);
    exp_t e;
    int t = 0;
    while (bus.ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (bus.ready !== 1'b1) begin
      n_chk++;
      $display("FAIL ready_timeout: got ready=%b, expected 1 within 50 cycles", bus.ready);
    end
    bus.start = 1'b1;
    bus.ain   = a;
    bus.bin   = b;
    bus.bbin  = bb;
    e.d = d; e.bo = bo; e.ov = ov; e.acc = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    if (sb.size() != 0) begin
      n_chk++;
      $display("FAIL drain_timeout: got %0d pending results, expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL global_timeout: got no finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vt[7];
    exp_t e;
    int   d0;
    int   sent;
    int   t;

    vt[0] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0};
    vt[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    vt[2] = '{16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b0};
`ifdef SUB_SATURATE_EN
    vt[3] = '{16'h8000, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vt[4] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};
`else
    vt[3] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
    vt[4] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1};
`endif
    vt[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vt[6] = '{16'hABCD, 16'h1234, 1'b0, 16'h9999, 1'b0, 1'b0};

    bus.start = 1'b0;
    bus.ain   = '0;
    bus.bin   = '0;
    bus.bbin  = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_diff", {16'd0, bus.diff}, 32'd0);
    chk("rst_bout", {31'd0, bus.bout}, 32'd0);
    chk("rst_overflow", {31'd0, bus.overflow}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_ready", {31'd0, bus.ready}, 32'd1);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      issue(vt[i].a, vt[i].b, vt[i].bb, vt[i].d, vt[i].bo, vt[i].ov);
      drain();
    end

    repeat (3) @(negedge clk);
    chk("hold_diff_idle", {16'd0, bus.diff}, 32'h9999);
    chk("hold_ready_idle", {31'd0, bus.ready}, 32'd1);

    // start pulsed while RUN must not launch a second operation
    d0 = done_cnt;
    issue(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0);
    bus.start = 1'b1;
    bus.ain   = 16'hFFFF;
    bus.bin   = 16'h0001;
    @(negedge clk);
    bus.start = 1'b0;
    drain();
    repeat (6) @(negedge clk);
    chk("run_start_ignored", done_cnt - d0, 32'd1);
    chk("run_start_result", {16'd0, bus.diff}, 32'h1000);

    // start held through DONE: second op accepted back-to-back
    d0 = done_cnt;
    bus.start = 1'b1;
    bus.ain   = 16'h00FF;
    bus.bin   = 16'h0F0F;
    bus.bbin  = 1'b0;
    e.d = 16'hF1F0; e.bo = 1'b1; e.ov = 1'b0; e.acc = cyc + 1;
    sb.push_back(e);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (bus.done !== 1'b1 && t < 20);
    bus.ain  = 16'h8000;
    bus.bin  = 16'h8000;
    bus.bbin = 1'b1;
    e.d = 16'hFFFF; e.bo = 1'b1; e.ov = 1'b0; e.acc = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    drain();
    repeat (6) @(negedge clk);
    chk("back_to_back_count", done_cnt - d0, 32'd2);

    // reset after the second slice: abandon, outputs cleared at once, no done
    issue(16'h1111, 16'h0001, 1'b0, 16'h1110, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    d0 = done_cnt;
    reset = 1'b1;
    #1;
    sb.delete();
    chk("midrst_diff", {16'd0, bus.diff}, 32'd0);
    chk("midrst_bout", {31'd0, bus.bout}, 32'd0);
    chk("midrst_overflow", {31'd0, bus.overflow}, 32'd0);
    chk("midrst_ready", {31'd0, bus.ready}, 32'd1);
    chk("midrst_done", {31'd0, bus.done}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    chk("midrst_no_done", done_cnt - d0, 32'd0);

    // random stream: a new op is offered on every ready cycle, so DONE overlaps the next start
    sent = 0;
    t    = 0;
    while (sent < 1000 && t < 20000) begin
      if (bus.ready === 1'b1) begin
        logic [15:0] a, b;
        logic        bb;
        a  = 16'($urandom);
        b  = 16'($urandom);
        bb = 1'($urandom_range(0, 1));
        bus.start = 1'b1;
        bus.ain   = a;
        bus.bin   = b;
        bus.bbin  = bb;
        e = model(a, b, bb);
        e.acc = cyc + 1;
        sb.push_back(e);
        sent++;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      t++;
    end
    bus.start = 1'b0;
    chk("random_ops_sent", sent, 32'd1000);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
